muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine feeding the HI/LO register.
// Multiplies (MULT/MULTU/MADD/MADDU/MSUB/MSUBU) complete after MUL_LAT cycles,
// plus one cycle for the HI/LO accumulate step. Divides (DIV/DIVU) use a
// restoring radix-2 loop of 32 iterations followed by a sign-fix cycle.
//
// Optional build macro MULDIV_DIV_EARLY_EN: when defined, a divide whose
// divisor is zero or whose dividend magnitude is below the divisor magnitude
// skips the iteration loop and completes one cycle after start.
//
// state | meaning
// IDLE  | waiting for start
// MUL   | multiply pipeline delay (down-counter)
// ACC   | HI/LO +/- product for MADD/MSUB variants
// DIV   | one restoring division step per cycle (down-counter)
// FIX   | apply quotient/remainder signs, divide-by-zero override
// DONE  | result presented, hilo_we pulses; new start accepted here
module muldiv_unit #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [63:0] hilo_rdata,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_ACC  = 3'd2,
        S_DIV  = 3'd3,
        S_FIX  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic        acc_q, acc_d;
    logic        sub_q, sub_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [63:0] hilo_q, hilo_d;
    logic [63:0] prod_q, prod_d;
    logic [63:0] result_q, result_d;
    logic        done_q, done_d;

    logic        accept;
    logic        in_div;
    logic        in_sgn;
    logic        in_acc;
    logic        early;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [63:0] acc_sum;
    logic [32:0] rem_sh;
    logic [31:0] trial;
    logic        trial_ok;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [63:0] div_result;

    // Decode the incoming operation and decide whether it is accepted this edge
    always_comb begin
        in_div = op[2] & op[1];
        in_sgn = ~op[0];
        in_acc = op[2] ^ op[1];
        accept = start & ~cancel & ((state_q == S_IDLE) | (state_q == S_DONE));
        mag_a  = (in_sgn & opa[31]) ? (32'd0 - opa) : opa;
        mag_b  = (in_sgn & opb[31]) ? (32'd0 - opb) : opb;
`ifdef MULDIV_DIV_EARLY_EN
        early  = in_div & ((opb == 32'd0) | (mag_a < mag_b));
`else
        early  = 1'b0;
`endif
    end

    // Arithmetic on the captured operands: product, accumulate, divide step, sign fix
    always_comb begin
        // Low 64 bits of the product of sign/zero-extended operands are exact
        mul_a      = {{32{sgn_q & a_q[31]}}, a_q};
        mul_b      = {{32{sgn_q & b_q[31]}}, b_q};
        product    = mul_a * mul_b;
        acc_sum    = sub_q ? (hilo_q - prod_q) : (hilo_q + prod_q);
        rem_sh     = {rem_q, quo_q[31]};
        trial_ok   = rem_sh >= {1'b0, b_q};
        trial      = rem_sh[31:0] - b_q;
        quo_fix    = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        rem_fix    = neg_rem_q ? (32'd0 - rem_q) : rem_q;
        div_result = div0_q ? {a_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
    end

    // Next-state logic; cancel always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = in_div ? (early ? S_FIX : S_DIV) : S_MUL;
            S_MUL:  if (cnt_q == 5'd0) state_d = acc_q ? S_ACC : S_DONE;
            S_ACC:  state_d = S_DONE;
            S_DIV:  if (cnt_q == 5'd0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = accept ? (in_div ? (early ? S_FIX : S_DIV) : S_MUL) : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (cancel) state_d = S_IDLE;
        done_d = (state_d == S_DONE);
    end

    // Datapath next values: capture on accept, then step per state
    always_comb begin
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        acc_d     = acc_q;
        sub_d     = sub_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        a_d       = a_q;
        b_d       = b_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        hilo_d    = hilo_q;
        prod_d    = prod_q;
        result_d  = result_q;
        if (accept) begin
            a_d       = opa;
            b_d       = in_div ? mag_b : opb;
            sgn_d     = in_sgn;
            acc_d     = in_acc;
            sub_d     = op[2];
            hilo_d    = hilo_rdata;
            cnt_d     = in_div ? 5'd31 : 5'(MUL_LAT - 1);
            quo_d     = early ? 32'd0 : mag_a;
            rem_d     = early ? mag_a : 32'd0;
            neg_quo_d = in_sgn & (opa[31] ^ opb[31]);
            neg_rem_d = in_sgn & opa[31];
            div0_d    = (opb == 32'd0);
        end else begin
            case (state_q)
                S_MUL: begin
                    if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
                    else if (acc_q) prod_d = product;
                    else if (!cancel) result_d = product;
                end
                S_ACC: if (!cancel) result_d = acc_sum;
                S_DIV: begin
                    if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
                    quo_d = {quo_q[30:0], trial_ok};
                    rem_d = trial_ok ? trial : rem_sh[31:0];
                end
                S_FIX: if (!cancel) result_d = div_result;
                default: ;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            acc_q     <= 1'b0;
            sub_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            hilo_q    <= '0;
            prod_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            acc_q     <= acc_d;
            sub_q     <= sub_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            a_q       <= a_d;
            b_q       <= b_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            hilo_q    <= hilo_d;
            prod_q    <= prod_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    // Outputs: busy decoded from state, write strobe and data from registers
    always_comb begin
        busy       = (state_q == S_MUL) | (state_q == S_ACC) |
                     (state_q == S_DIV) | (state_q == S_FIX);
        done       = done_q;
        hilo_we    = done_q;
        hilo_wdata = result_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {HI,LO} and the
// completion edge; a negedge monitor pops and compares on every write.
module tb_muldiv_unit;

    localparam int MLAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [63:0] hilo_rdata;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        hilo_we;
    logic [63:0] hilo_wdata;

    typedef struct {
        logic [63:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    muldiv_unit #(.MUL_LAT(MLAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .hilo_rdata (hilo_rdata),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every write must match the oldest expectation, at the right edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (hilo_we || done)) begin
            total++;
            if (hilo_we !== done) begin
                bad++;
                $display("FAIL we_eq_done: hilo_we=%b done=%b", hilo_we, done);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: wdata=%h at edge %0d", hilo_wdata, cyc);
            end else begin
                e = sb.pop_front();
                if (hilo_wdata !== e.data) begin
                    bad++;
                    $display("FAIL %s data: got %h want %h", e.name, hilo_wdata, e.data);
                end
                total++;
                if (cyc != e.due) begin
                    bad++;
                    $display("FAIL %s latency: done at edge %0d want %0d", e.name, cyc, e.due);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one start pulse; returns at the negedge after the accepting edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] h, input bit push, input logic [63:0] exp_data,
                         input int lat, input string nm);
        exp_t e;
        @(negedge clk);
        start      = 1'b1;
        op         = o;
        opa        = a;
        opb        = b;
        hilo_rdata = h;
        if (push) begin
            e.data = exp_data;
            e.due  = cyc + 1 + lat;
            e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d results never written (first %s)",
                     sb.size(), sb[0].name);
            sb.delete();
        end
    endtask

    function automatic int dlat(input bit early_ok);
`ifdef MULDIV_DIV_EARLY_EN
        return early_ok ? 1 : 33;
`else
        return early_ok ? 33 : 33;
`endif
    endfunction

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cancel     = 1'b0;
        op         = 3'd0;
        opa        = '0;
        opb        = '0;
        hilo_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_we", {63'd0, hilo_we}, 64'd0);
        chk("reset_wdata", hilo_wdata, 64'd0);
        rst = 1'b0;

        // MULT with busy profile across the pipeline
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFA, MLAT, "mult_neg");
        chk("mult_busy_e0", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("mult_busy_e1", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("mult_busy_e2", {63'd0, busy}, 64'd0);
        drain();
        repeat (2) @(negedge clk);
        chk("wdata_hold", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFA);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1, 64'hFFFF_FFFE_0000_0001, MLAT, "multu_max");
        drain();
        issue(3'd2, 32'd3, 32'd4, 64'd5, 1, 64'h0000_0000_0000_0011, MLAT + 1, "madd");
        drain();
        issue(3'd5, 32'd3, 32'd4, 64'd5, 1, 64'hFFFF_FFFF_FFFF_FFF9, MLAT + 1, "msubu");
        drain();
        issue(3'd4, 32'hFFFF_FFFF, 32'd2, 64'd0, 1, 64'h0000_0000_0000_0002, MLAT + 1, "msub_neg");
        drain();
        issue(3'd3, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0, MLAT + 1, "maddu_wrap");
        drain();

        // Divides
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 64'd0, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, dlat(0), "div_m7_2");
        drain();
        issue(3'd7, 32'd7, 32'd2, 64'd0, 1, {32'd1, 32'd3}, dlat(0), "divu_7_2");
        drain();
        issue(3'd6, 32'd7, 32'hFFFF_FFFE, 64'd0, 1, {32'd1, 32'hFFFF_FFFD}, dlat(0), "div_7_m2");
        drain();
        issue(3'd7, 32'hFFFF_FFFF, 32'd16, 64'd0, 1, {32'd15, 32'h0FFF_FFFF}, dlat(0), "divu_big");
        drain();
        issue(3'd7, 32'd7, 32'd0, 64'd0, 1, {32'd7, 32'hFFFF_FFFF}, dlat(1), "divu_by0");
        drain();
        issue(3'd6, 32'hFFFF_FFF9, 32'd0, 64'd0, 1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, dlat(1), "div_by0");
        drain();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1, {32'd0, 32'h8000_0000}, dlat(0), "div_ovf");
        drain();
        issue(3'd7, 32'd3, 32'd10, 64'd0, 1, {32'd3, 32'd0}, dlat(1), "divu_small");
        drain();
        issue(3'd6, 32'hFFFF_FFFD, 32'd5, 64'd0, 1, {32'hFFFF_FFFD, 32'd0}, dlat(1), "div_small_neg");
        drain();

        // Start while busy is ignored
        issue(3'd7, 32'd7, 32'd2, 64'd0, 1, {32'd1, 32'd3}, dlat(0), "divu_busy");
        issue(3'd0, 32'd5, 32'd5, 64'd0, 0, 64'd0, 0, "ignored");
        drain();

        // Back-to-back: second start lands in the DONE cycle of the first
        issue(3'd0, 32'd6, 32'd7, 64'd0, 1, 64'd42, MLAT, "b2b_first");
        @(negedge clk);
        issue(3'd2, 32'd2, 32'd2, 64'd10, 1, 64'd14, MLAT + 1, "b2b_second");
        drain();

        // Cancel during a divide: no write, then a normal multiply
        issue(3'd6, 32'd100, 32'd3, 64'd0, 0, 64'd0, 0, "div_cancel");
        repeat (10) @(negedge clk);
        chk("cancel_busy_before", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy_after", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        issue(3'd1, 32'd2, 32'd3, 64'd0, 1, 64'd6, MLAT, "mult_after_cancel");
        drain();

        // Cancel together with start: start is dropped
        cancel = 1'b1;
        issue(3'd1, 32'd9, 32'd9, 64'd0, 0, 64'd0, 0, "cancel_start");
        cancel = 1'b0;
        chk("cancel_start_busy", {63'd0, busy}, 64'd0);
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-divide
        issue(3'd6, 32'd100, 32'd3, 64'd0, 0, 64'd0, 0, "div_reset");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_we", {63'd0, hilo_we}, 64'd0);
        chk("rst_mid_wdata", hilo_wdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_after_busy", {63'd0, busy}, 64'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
